prio_arbiter: RTL and testbench

PRIO_ARBITER -- requirements
Module: prio_arbiter

---
 rtl/prio_arbiter_pkg.sv | 12 +
 rtl/prio_arbiter_encoder.sv | 26 ++
 rtl/prio_arbiter.sv | 144 ++++++++++++++
 tb/tb_prio_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/prio_arbiter_pkg.sv
// Shared types and constants for the priority/round-robin arbiter.
package prio_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/prio_arbiter_encoder.sv
// Combinational N-to-W priority encoder: reports the highest set bit of req.
module priority_encoder_n
  import prio_arbiter_pkg::*;
#(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         any_valid
);

  // Later (higher) set bits overwrite earlier ones, so the highest index wins.
  always_comb begin
    idx = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        idx = W'(i);
      end else begin
        idx = idx;
      end
    end
    any_valid = |req;
  end

endmodule

// File: rtl/prio_arbiter.sv
// Fixed-priority / round-robin arbiter with a held grant released by ack.
module prio_arbiter
  import prio_arbiter_pkg::*;
#(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         ack,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_valid
);

  state_t         state_r;
  logic [W-1:0]   ptr_r;
  logic [N-1:0]   gnt_r;
  logic [W-1:0]   gnt_idx_r;
  logic           gnt_valid_r;

  logic [N-1:0]   rev_req_s;
  logic [N-1:0]   rev_masked_s;
  logic [W-1:0]   fix_idx_s;
  logic           fix_any_s;
  logic [W-1:0]   rr_m_ridx_s;
  logic           rr_m_any_s;
  logic [W-1:0]   rr_a_ridx_s;
  logic           rr_a_any_s;
  logic [W-1:0]   win_idx_s;
  logic           win_valid_s;
  logic [N-1:0]   win_onehot_s;
  logic [W-1:0]   nxt_ptr_s;

  // Bit-reversed views let the highest-first encoder find the lowest index;
  // the masked view only keeps requests at or above the round-robin pointer.
  always_comb begin
    rev_req_s    = {N{1'b0}};
    rev_masked_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      rev_req_s[i] = req[N-1-i];
      if (W'(N-1-i) >= ptr_r) begin
        rev_masked_s[i] = req[N-1-i];
      end else begin
        rev_masked_s[i] = 1'b0;
      end
    end
  end

  priority_encoder_n #(.N(N), .W(W)) u_enc_fixed (
    .req       (req),
    .idx       (fix_idx_s),
    .any_valid (fix_any_s)
  );

  priority_encoder_n #(.N(N), .W(W)) u_enc_rr_masked (
    .req       (rev_masked_s),
    .idx       (rr_m_ridx_s),
    .any_valid (rr_m_any_s)
  );

  priority_encoder_n #(.N(N), .W(W)) u_enc_rr_all (
    .req       (rev_req_s),
    .idx       (rr_a_ridx_s),
    .any_valid (rr_a_any_s)
  );

  // Winner selection, its one-hot form and the post-grant pointer value.
  always_comb begin
    win_idx_s    = {W{1'b0}};
    win_valid_s  = 1'b0;
    win_onehot_s = {N{1'b0}};
    if (mode == MODE_FIXED) begin
      win_idx_s   = fix_idx_s;
      win_valid_s = fix_any_s;
    end else if (rr_m_any_s) begin
      win_idx_s   = W'(N-1) - rr_m_ridx_s;
      win_valid_s = 1'b1;
    end else begin
      win_idx_s   = W'(N-1) - rr_a_ridx_s;
      win_valid_s = rr_a_any_s;
    end
    for (int i = 0; i < N; i++) begin
      win_onehot_s[i] = (W'(i) == win_idx_s);
    end
    if (win_idx_s == W'(N-1)) begin
      nxt_ptr_s = {W{1'b0}};
    end else begin
      nxt_ptr_s = win_idx_s + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Arbitration FSM with registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ptr_r       <= {W{1'b0}};
      gnt_r       <= {N{1'b0}};
      gnt_idx_r   <= {W{1'b0}};
      gnt_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (win_valid_s) begin
            state_r     <= GRANT;
            gnt_r       <= win_onehot_s;
            gnt_idx_r   <= win_idx_s;
            gnt_valid_r <= 1'b1;
            if (mode == MODE_RR) begin
              ptr_r <= nxt_ptr_s;
            end else begin
              ptr_r <= ptr_r;
            end
          end else begin
            gnt_r       <= {N{1'b0}};
            gnt_valid_r <= 1'b0;
          end
        end
        GRANT: begin
          if (ack) begin
            state_r     <= IDLE;
            gnt_r       <= {N{1'b0}};
            gnt_valid_r <= 1'b0;
          end else begin
            gnt_r       <= gnt_r;
            gnt_valid_r <= gnt_valid_r;
          end
        end
        default: begin
          state_r     <= IDLE;
          gnt_r       <= {N{1'b0}};
          gnt_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_r;
  assign gnt_idx   = gnt_idx_r;
  assign gnt_valid = gnt_valid_r;

endmodule

// File: tb/tb_prio_arbiter.sv
// Directed self-checking bench for prio_arbiter (N = 16 and N = 5 instances).
module tb_prio_arbiter;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic [15:0] req;
  logic        ack;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic [4:0]  req5;
  logic        ack5;
  logic [4:0]  gnt5;
  logic [2:0]  gnt_idx5;
  logic        gnt_valid5;

  int n_cmp = 0;
  int n_err = 0;

  prio_arbiter #(.N(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode), .ack(ack),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid)
  );

  prio_arbiter #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .mode(mode), .ack(ack5),
    .gnt(gnt5), .gnt_idx(gnt_idx5), .gnt_valid(gnt_valid5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input string tag, input int idx);
    logic [15:0] e;
    e = 16'h0001 << idx;
    chk({tag, ".gnt"}, 64'(gnt), 64'(e));
    chk({tag, ".idx"}, 64'(gnt_idx), 64'(idx));
    chk({tag, ".valid"}, 64'(gnt_valid), 64'd1);
  endtask

  task automatic chk_idle(input string tag, input int idx);
    chk({tag, ".gnt"}, 64'(gnt), 64'd0);
    chk({tag, ".idx"}, 64'(gnt_idx), 64'(idx));
    chk({tag, ".valid"}, 64'(gnt_valid), 64'd0);
  endtask

  task automatic chk_grant5(input string tag, input int idx);
    logic [4:0] e;
    e = 5'b00001 << idx;
    chk({tag, ".gnt"}, 64'(gnt5), 64'(e));
    chk({tag, ".idx"}, 64'(gnt_idx5), 64'(idx));
    chk({tag, ".valid"}, 64'(gnt_valid5), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; req = 16'h0000; ack = 1'b0;
    req5 = 5'b00000; ack5 = 1'b0;
    step();
    step();
    chk_idle("reset", 0);
    rst_n = 1'b1;
    step();
    chk_idle("post_reset_idle", 0);

    // Fixed priority, 0x8001: highest index wins and is held without ack.
    mode = 1'b0; req = 16'h8001;
    step();
    chk_grant("fix_first", 15);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_grant($sformatf("fix_hold%0d", i), 15);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk_idle("fix_bubble", 15);
    step();
    chk_grant("fix_regrant", 15);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk_idle("fix_release", 15);

    // Round-robin over all requesters: 0..15 then wrap to 0.
    mode = 1'b1; req = 16'hFFFF;
    for (int k = 0; k <= 16; k++) begin
      step();
      chk_grant($sformatf("rr_seq%0d", k), k % 16);
      ack = 1'b1;
      step();
      ack = 1'b0;
      chk_idle($sformatf("rr_bub%0d", k), k % 16);
    end

    // Pointer wrap at N-1: grant 14, then 0x0003 yields 0 then 1.
    req = 16'h4000;
    step();
    chk_grant("rr_idx14", 14);
    ack = 1'b1; req = 16'h0003;
    step();
    ack = 1'b0;
    step();
    chk_grant("rr_wrap0", 0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    chk_grant("rr_wrap1", 1);
    ack = 1'b1; req = 16'h0000;
    step();
    ack = 1'b0;

    // Granted request withdrawn: grant holds until ack, then stays idle.
    mode = 1'b0; req = 16'h0010;
    step();
    chk_grant("wd_grant", 4);
    req = 16'h0000;
    step();
    chk_grant("wd_hold0", 4);
    step();
    chk_grant("wd_hold1", 4);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk_idle("wd_clear", 4);
    step();
    chk_idle("wd_stay_idle", 4);

    // ack in IDLE is ignored: request and ack at the same edge still grants.
    ack = 1'b1; req = 16'h0010;
    step();
    chk_grant("idle_ack_ignored", 4);
    step();
    ack = 1'b0; req = 16'h0000;
    chk_idle("ack_release", 4);

    // Asynchronous reset mid-grant clears outputs and pointer history.
    mode = 1'b1; req = 16'h0100;
    step();
    chk_grant("pre_reset", 8);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_reset", 0);
    req = 16'hFFFF;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_grant("rr_after_reset", 0);
    ack = 1'b1; req = 16'h0000;
    step();
    ack = 1'b0;

    // N = 5 round-robin: grant 4 wraps the pointer to 0.
    req5 = 5'b10001;
    step();
    chk_grant5("n5_first", 0);
    ack5 = 1'b1;
    step();
    ack5 = 1'b0;
    chk({"n5_bubble", ".valid"}, 64'(gnt_valid5), 64'd0);
    step();
    chk_grant5("n5_idx4", 4);
    ack5 = 1'b1;
    step();
    ack5 = 1'b0;
    step();
    chk_grant5("n5_wrap0", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
